moka_fetch_unit: RTL
====================

Name: moka_fetch_unit

Overview:
Parametrised instruction-fetch front end for the moka RV32 pipeline. It replaces the single-register PC / instruction-memory fetch path with a decoupled request/response fetcher. Features:
- Credit-limited outstanding instruction-memory requests.
- In-order prefetch FIFO of {instr, pc}.
- valid/ready handshake to decode.
- Redirect from execute that flushes the FIFO and discards stale in-flight responses.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 4, prefetch entries; must be ≥2, any integer; also the credit limit.
- CNT_W, $clog2(FIFO_DEPTH+1), derived width for occupancy, outstanding and drop counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global enable; 0 freezes fetch state.
- redirect_valid  in  1  execute-stage taken branch/jump.
- redirect_pc  in  DATA_WIDTH  target PC; bits [1:0] ignored.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  DATA_WIDTH  word-aligned fetch address.
- imem_rsp_valid  in  1  in-order response valid; cannot be back-pressured.
- imem_rsp_data  in  DATA_WIDTH  fetched instruction.
- instr_valid  out  1  FIFO head valid to decode.
- instr_ready  in  1  decode accepts (= !StallD).
- instr_data  out  DATA_WIDTH  head instruction.
- instr_pc  out  DATA_WIDTH  head PC.
- instr_pc_plus4  out  DATA_WIDTH  head PC + 4.

Behaviour:
- Reset (rst=1 at a clk edge):
  - req_pc and rsp_pc are set to RESET_PC.
  - fifo_count, outstanding and drop_cnt are set to 0.
  - During and after reset until the first request: imem_req_valid=0, instr_valid=0, imem_req_addr=RESET_PC, instr_data=0, instr_pc=0, instr_pc_plus4=0.
  - Reset mid-operation discards all FIFO and in-flight state. Responses arriving later are not dropped by the counter; the memory side must be reset together with this block.
- Request issue:
  - imem_req_valid = en & !rst & !redirect_valid & (fifo_count + outstanding < FIFO_DEPTH).
  - imem_req_addr = req_pc.
  - On accept (valid & ready): req_pc += 4 and outstanding += 1.
- Response:
  - If drop_cnt > 0, the response is discarded and drop_cnt -= 1.
  - Otherwise {imem_rsp_data, rsp_pc} is written to the FIFO tail and rsp_pc += 4.
  - Either way, outstanding -= 1.
  - Responses are consumed even when en=0; the credit rule guarantees a free slot, so overflow is impossible. An assertion must flag overflow.
  - Accept and response in the same cycle leave outstanding unchanged.
- Output:
  - instr_valid = (fifo_count != 0) & en & !redirect_valid.
  - Pop on instr_valid & instr_ready.
  - There is no bypass: a response that lands at edge t is visible at the output after t. Minimum latency is request accept → instr_valid = L + 1 cycles, where L is the memory latency.
  - Push and pop in the same cycle leave fifo_count unchanged; read/write pointers wrap from FIFO_DEPTH-1 to 0.
  - instr_data/instr_pc hold the FIFO head whenever it is non-empty; when empty they are don't-care, but they must not be X after reset.
- Redirect (redirect_valid=1, en=1):
  - FIFO is flushed (count 0, pointers 0).
  - req_pc and rsp_pc are set to {redirect_pc[DATA_WIDTH-1:2], 2'b00}.
  - drop_cnt is set to outstanding_next, where outstanding_next excludes any response arriving this cycle. A response arriving in the redirect cycle is itself dropped.
  - No request is issued and no pop occurs in the redirect cycle.
  - Back-to-back redirects: each one reloads the PCs, and drop_cnt is recomputed from the current outstanding count.
- en=0: PCs, FIFO contents and pointers hold; only response capture and the outstanding/drop counters advance; redirect is ignored.
- Arithmetic: PCs wrap modulo 2^DATA_WIDTH. Counters never exceed FIFO_DEPTH.

Decomposition:
- Package moka_fetch_pkg holds:
  - INSTR_BYTES=4.
  - RV32 NOP constant 32'h0000_0013.
  - Fetch-entry struct {instr, pc}.
  - Helper function for counter width.
- One sub-module: moka_sync_fifo (WIDTH, DEPTH, synchronous flush, push/pop, count, full/empty), reusable for later load/store queues.

Test Plan:
1. Reset then zero-wait memory (ready=1, L=1), instr_ready=1 → instr_pc 0x0, 0x4, 0x8… consecutively; first instr_valid 2 cycles after rst deasserts.
2. instr_ready=0 with FIFO_DEPTH=4, L=1:
   - Expected: exactly 4 requests issued (0x0–0xC), then imem_req_valid=0 and fifo_count=4.
   - Release instr_ready: data emerges in order, and issue resumes at 0x10.
3. L=3 with 3 outstanding, redirect_pc=0x103 →
   - Next request address is 0x100.
   - 3 stale responses are dropped.
   - First delivered instr_pc=0x100.
4. Redirect in the same cycle as a response arrival and an instr_ready pop:
   - Response is dropped; no pop occurs.
   - instr_valid=0 that cycle.
   - FIFO is empty afterwards.
5. en=0 for 5 cycles while 2 responses are in flight:
   - Both responses are captured; no new requests; instr_valid=0.
   - Re-enable: both are delivered in order with the correct PCs.
6. Assert rst with a full FIFO and 2 outstanding → after the next edge, instr_valid=0, imem_req_addr=RESET_PC, and all counters are 0.

Source files
------------

// File: rtl/moka_fetch_pkg.sv
// Shared definitions for the moka instruction-fetch front end.
package moka_fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  // One prefetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Width needed to count from 0 up to and including depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/moka_sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and full/empty flags.
module moka_sync_fifo
  import moka_fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Occupancy follows push/pop; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and count state; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/moka_fetch_unit.sv
// Decoupled instruction fetcher: credit-limited requests, in-order
// prefetch FIFO toward decode, redirect flush with stale-response drop.
module moka_fetch_unit
  import moka_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 4,
  parameter int                    CNT_W      = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic [DATA_WIDTH-1:0] instr_pc_plus4
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
  } entry_t;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(INSTR_BYTES);
  localparam logic [CNT_W:0]        CREDITS = (CNT_W + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [DATA_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic [DATA_WIDTH-1:0] redir_tgt;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  redir, credit_ok, req_fire, rsp_keep, pop, show;
  entry_t                wr_entry, head;

  // A redirect only acts while enabled; the target is forced word-aligned.
  assign redir     = redirect_valid & en;
  assign redir_tgt = redirect_pc & ~DATA_WIDTH'(3);

  // Every FIFO slot is either occupied or reserved by an in-flight request,
  // which is what makes unstallable responses safe to capture.
  assign credit_ok      = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < CREDITS;
  assign imem_req_valid = en & ~rst & ~redirect_valid & credit_ok;
  assign imem_req_addr  = rst ? RESET_PC : req_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Responses from before a redirect (including one landing in the redirect
  // cycle) are discarded; everything else is captured even with en low.
  assign rsp_keep = imem_rsp_valid & (drop_cnt_q == '0) & ~redir;
  assign wr_entry = '{instr: imem_rsp_data, pc: rsp_pc_q};

  assign instr_valid    = ~fifo_empty & en & ~redirect_valid & ~rst;
  assign pop            = instr_valid & instr_ready;
  assign show           = ~fifo_empty & ~rst;
  assign instr_data     = show ? head.instr : '0;
  assign instr_pc       = show ? head.pc : '0;
  assign instr_pc_plus4 = show ? head.pc + PC_STEP : '0;

  moka_sync_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redir),
    .push_i  (rsp_keep),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state for fetch PCs and the outstanding/drop counters.
  always_comb begin
    req_pc_d      = req_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    if (redir) begin
      req_pc_d   = redir_tgt;
      rsp_pc_d   = redir_tgt;
      drop_cnt_d = outstanding_q - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) req_pc_d = req_pc_q + PC_STEP;
      if (rsp_keep) rsp_pc_d = rsp_pc_q + PC_STEP;
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  // Fetch control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc_q      <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      req_pc_q      <= req_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // A captured response must always find room in the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(rsp_keep && fifo_full && !pop));
  end

endmodule
